// File: rtl/gray_decode_arbiter_if.sv
// gray_decode_arbiter_if
//   Bundles the requester-side handshake and the decoder-side strobe/data
//   signals of gray_decode_arbiter.
//   Requester side : reqValid/reqData in, reqReady out,
//                    rspValid/rspData/rspError out, busy out.
//   Decoder side   : decStrobe/decData out, decOutStrobe/decDataOut in.
//   slave  modport : the arbiter.
//   master modport : the environment (requesters plus decoder).
interface gray_decode_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ*WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]       reqReady;
  logic [NUM_REQ-1:0]       rspValid;
  logic [WIDTH-1:0]         rspData;
  logic                     rspError;
  logic                     busy;
  logic                     decStrobe;
  logic [WIDTH-1:0]         decData;
  logic                     decOutStrobe;
  logic [WIDTH-1:0]         decDataOut;

  modport slave (
    input  reqValid, reqData, decOutStrobe, decDataOut,
    output reqReady, rspValid, rspData, rspError, busy, decStrobe, decData
  );

  modport master (
    output reqValid, reqData, decOutStrobe, decDataOut,
    input  reqReady, rspValid, rspData, rspError, busy, decStrobe, decData
  );
endinterface

// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter
//   Shares one GrayToBinary decoder among NUM_REQ requesters. A round-robin
//   scan picks one requester in IDLE, its Gray word is strobed into the
//   decoder, and the decoder's answer (or a timeout error after TIMEOUT
//   cycles in WAIT) is returned to that requester as a one-cycle pulse.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : slave modport of gray_decode_arbiter_if
//          reqValid/reqData/reqReady  requester handshake (reqReady is
//                                     combinational, one-hot, IDLE only)
//          rspValid/rspData/rspError  registered one-hot response pulse
//          busy                       registered, high outside IDLE
//          decStrobe/decData          registered drive to decoder
//          decOutStrobe/decDataOut    decoder answer, honoured in WAIT only
module gray_decode_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_decode_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  logic [1:0]         state_q,      state_d;
  logic [PTR_W-1:0]   ptr_q,        ptr_d;
  logic [PTR_W-1:0]   owner_q,      owner_d;
  logic [WIDTH-1:0]   data_q,       data_d;
  logic [TMR_W-1:0]   timer_q,      timer_d;
  logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q,   rsp_data_d;
  logic               rsp_error_q,  rsp_error_d;
  logic               dec_strobe_q, dec_strobe_d;
  logic               busy_q,       busy_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic [WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0] req_ready;

  // Round-robin scan starting at ptr_q; the extra bit of cand lets the
  // wrap-around be a single conditional subtract for any NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!win_found && bus.reqValid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_data = bus.reqData[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst so that every output reads zero while reset is held,
  // even though IDLE is the reset state.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && win_found && !rst) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    data_d       = data_q;
    timer_d      = timer_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    dec_strobe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          data_d       = win_data;
          owner_d      = win_idx;
          dec_strobe_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A decoder answer on the timeout edge still counts as success.
        if (bus.decOutStrobe) begin
          rsp_data_d           = bus.decDataOut;
          rsp_error_d          = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESPOND;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rsp_data_d           = '0;
          rsp_error_d          = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RESPOND: begin
        if (owner_q == PTR_W'(NUM_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      data_q       <= '0;
      timer_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      dec_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      dec_strobe_q <= dec_strobe_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.reqReady  = req_ready;
  assign bus.rspValid  = rsp_valid_q;
  assign bus.rspData   = rsp_data_q;
  assign bus.rspError  = rsp_error_q;
  assign bus.busy      = busy_q;
  assign bus.decStrobe = dec_strobe_q;
  // dataReg is itself the registered decoder input; it holds through WAIT.
  assign bus.decData   = data_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed bench for gray_decode_arbiter with a latency-programmable
// GrayToBinary decoder model (latency 0 means the decoder never answers).
module tb_gray_decode_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_decode_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  gray_decode_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors      = 0;
  int checks      = 0;
  int rsp_pulses  = 0;
  int exp_pulses  = 0;

  int         m_lat     = 0;
  int         m_cnt     = 0;
  logic       m_fire    = 1'b0;
  logic [W-1:0] m_dout  = '0;
  logic       spur      = 1'b0;
  logic [W-1:0] spur_data = '0;

  assign bus.decOutStrobe = m_fire | spur;
  assign bus.decDataOut   = spur ? spur_data : m_dout;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Decoder model: strobe seen in cycle c -> outStrobe high in cycle c+m_lat.
  always @(negedge clk) begin
    m_fire = 1'b0;
    if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_fire = 1'b1;
    end
    if (bus.decStrobe && m_lat != 0) begin
      m_cnt  = m_lat;
      m_dout = g2b(bus.decData);
    end
  end

  always @(negedge clk) begin
    if (bus.rspValid != '0) rsp_pulses = rsp_pulses + 1;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [W-1:0] d);
    bus.reqValid[k]        = 1'b1;
    bus.reqData[k*W +: W]  = d;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after accept.
  task automatic wait_grant(output int k);
    logic [N-1:0] g;
    logic         found;
    k     = -1;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      g = bus.reqReady & bus.reqValid;
      if (g != '0) begin
        found = 1'b1;
        chk("grant_onehot", W'($countones(bus.reqReady)), W'(1));
        for (int j = 0; j < N; j++) if (g[j]) k = j;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", W'(found), W'(1));
    if (k < 0) k = 0;
    @(negedge clk);
  endtask

  // n = cycle index of rspValid counting the cycle after accept as 1.
  task automatic wait_rsp(output int n);
    n = 1;
    while (bus.rspValid == '0 && n < 64) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("rsp_seen", W'(bus.rspValid != '0), W'(1));
    exp_pulses = exp_pulses + 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reqReady"},  W'(bus.reqReady),  '0);
    chk({tag, "_rspValid"},  W'(bus.rspValid),  '0);
    chk({tag, "_rspData"},   bus.rspData,       '0);
    chk({tag, "_rspError"},  W'(bus.rspError),  '0);
    chk({tag, "_busy"},      W'(bus.busy),      '0);
    chk({tag, "_decStrobe"}, W'(bus.decStrobe), '0);
    chk({tag, "_decData"},   bus.decData,       '0);
  endtask

  initial begin
    int k;
    int n;
    logic [W-1:0] t2_in  [N];
    logic [W-1:0] t2_out [N];
    logic [W-1:0] words  [N];
    logic [N-1:0] mask;
    logic [63:0]  m64;
    int unsigned  w;

    t2_in  = '{32'h1, 32'h3, 32'h2, 32'h6};
    t2_out = '{32'h1, 32'h2, 32'h3, 32'h4};

    bus.reqValid = '0;
    bus.reqData  = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    bus.reqValid = '1;
    #1;
    chk_all_zero("reset");
    bus.reqValid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single request, L=2: requester 1 sends Gray 7 -> binary 5.
    m_lat = 2;
    set_req(1, 32'h7);
    wait_grant(k);
    bus.reqValid = '0;
    chk("t1_grant", W'(k), W'(1));
    chk("t1_decStrobe", W'(bus.decStrobe), W'(1));
    chk("t1_decData", bus.decData, 32'h7);
    chk("t1_busy", W'(bus.busy), W'(1));
    wait_rsp(n);
    chk("t1_latency", W'(n), W'(4));
    chk("t1_rspValid", W'(bus.rspValid), W'(4'b0010));
    chk("t1_rspData", bus.rspData, 32'h5);
    chk("t1_rspError", W'(bus.rspError), W'(0));

    // All requesters continuously active from reset: order 0,1,2,3,0,1.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, t2_in[i]);
    for (int i = 0; i < 6; i++) begin
      wait_grant(k);
      chk("t2_grant_order", W'(k), W'(i % N));
      wait_rsp(n);
      chk("t2_rspValid", W'(bus.rspValid), W'(1 << (i % N)));
      chk("t2_rspData", bus.rspData, t2_out[i % N]);
    end
    bus.reqValid = '0;

    // Decoder silent, TIMEOUT=8: error response 10 cycles after accept.
    m_lat = 0;
    set_req(0, 32'h1234);
    wait_grant(k);
    bus.reqValid = '0;
    chk("t3_grant", W'(k), W'(0));
    wait_rsp(n);
    chk("t3_latency", W'(n), W'(TO + 2));
    chk("t3_rspValid", W'(bus.rspValid), W'(4'b0001));
    chk("t3_rspData", bus.rspData, '0);
    chk("t3_rspError", W'(bus.rspError), W'(1));
    m_lat = 2;
    set_req(2, 32'h7);
    wait_grant(k);
    bus.reqValid = '0;
    chk("t3b_grant", W'(k), W'(2));
    wait_rsp(n);
    chk("t3b_latency", W'(n), W'(4));
    chk("t3b_rspData", bus.rspData, 32'h5);
    chk("t3b_rspError", W'(bus.rspError), W'(0));

    // Decoder answer lands on the timeout edge: data wins.
    m_lat = TO;
    set_req(2, 32'h6);
    wait_grant(k);
    bus.reqValid = '0;
    chk("t4_grant", W'(k), W'(2));
    wait_rsp(n);
    chk("t4_latency", W'(n), W'(TO + 2));
    chk("t4_rspValid", W'(bus.rspValid), W'(4'b0100));
    chk("t4_rspData", bus.rspData, 32'h4);
    chk("t4_rspError", W'(bus.rspError), W'(0));

    // Spurious decoder strobe while idle.
    m_lat = 0;
    @(negedge clk);
    spur_data = 32'hdeadbeef;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    #1;
    chk("t5_spur_no_rsp", W'(rsp_pulses), W'(exp_pulses));
    chk("t5_spur_busy", W'(bus.busy), W'(0));
    @(negedge clk);

    // Asynchronous reset in WAIT with requester 3 in flight (ptr was 3).
    set_req(3, 32'h55);
    wait_grant(k);
    chk("t5_grant_pre", W'(k), W'(3));
    set_req(2, 32'h6);
    set_req(3, 32'h6);
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_wait_busy", W'(bus.busy), W'(1));
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    bus.reqValid = '0;
    @(negedge clk);
    rst = 1'b0;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("t5_late_no_rsp", W'(rsp_pulses), W'(exp_pulses));
    chk("t5_late_busy", W'(bus.busy), W'(0));
    m_lat = 2;
    bus.reqValid = 4'b1100;
    wait_grant(k);
    bus.reqValid = '0;
    chk("t5_post_reset_grant", W'(k), W'(2));
    wait_rsp(n);
    chk("t5_rspValid", W'(bus.rspValid), W'(4'b0100));
    chk("t5_rspData", bus.rspData, 32'h4);

    // Random traffic, latency 1..5.
    for (int it = 0; it < 1024; it++) begin
      m_lat = int'($urandom_range(1, 5));
      mask  = N'($urandom_range(1, (1 << N) - 1));
      for (int j = 0; j < N; j++) begin
        if (mask[j]) begin
          w   = $urandom_range(3, W);
          m64 = (64'd1 << w) - 64'd1;
          words[j] = $urandom & m64[W-1:0];
          set_req(j, words[j]);
        end else begin
          bus.reqValid[j] = 1'b0;
        end
      end
      wait_grant(k);
      bus.reqValid = '0;
      chk("rand_grant_valid", W'(mask[k]), W'(1));
      wait_rsp(n);
      chk("rand_owner", W'(bus.rspValid), W'(1 << k));
      chk("rand_data", bus.rspData, g2b(words[k]));
      chk("rand_err", W'(bus.rspError), W'(0));
      chk("rand_latency", W'(n), W'(m_lat + 2));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rsp_pulse_count", W'(rsp_pulses), W'(exp_pulses));
    chk("final_busy", W'(bus.busy), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_decode_arbiter.md
# gray_decode_arbiter

Round-robin arbiter and sequencer that shares one GrayToBinary decoder among NUM_REQ requesters. It accepts one Gray-coded word at a time from the winning requester, strobes it into the decoder, and waits for the decoder's output strobe. It then returns the binary result to the owning requester, or flags an error if the decoder does not answer within TIMEOUT cycles. It sits between the requester ports and a single GrayToBinary instance.

## Interface
- WIDTH, 32, data width; must match the attached decoder.
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT, 64, cycles in WAIT before an error response (2..65535).

- clk  input  1  system clock.
- rst  input  1  reset; one clock; asynchronous, active-high.
- reqValid  input  NUM_REQ  per-requester request; held with reqData until reqReady.
- reqData  input  NUM_REQ*WIDTH  Gray word; requester k occupies bits [k*WIDTH +: WIDTH].
- reqReady  output  NUM_REQ  one-hot accept; a transfer occurs on reqValid[k] & reqReady[k] at the clk edge.
- rspValid  output  NUM_REQ  one-hot, one-cycle response pulse to the owning requester.
- rspData  output  WIDTH  binary result; valid with rspValid.
- rspError  output  1  timeout flag; valid with rspValid.
- busy  output  1  high in every state other than IDLE.
- decStrobe  output  1  drives decoder inStrobe.
- decData  output  WIDTH  drives decoder dataIn.
- decOutStrobe  input  1  from decoder outStrobe.
- decDataOut  input  WIDTH  from decoder dataOut.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - Winner = first k with reqValid[k], scanning ptr, ptr+1, … mod NUM_REQ.
  - reqReady[winner] = 1 combinationally, in IDLE only. All other reqReady bits are 0.
  - On the accept edge: latch reqData slice into dataReg, latch owner = winner, go to ISSUE.
  - No reqValid: stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - decStrobe = 1, decData = dataReg.
  - Clear timer; go to WAIT.
- **WAIT**
  - decData keeps holding dataReg.
  - If decOutStrobe is sampled high: latch decDataOut into rspData, rspError = 0, go to RESPOND.
  - Else if timer == TIMEOUT-1: rspData = 0, rspError = 1, go to RESPOND.
  - Else: timer + 1.
  - decOutStrobe and timeout on the same edge: data wins, rspError = 0.
- **RESPOND** (exactly 1 cycle)
  - rspValid[owner] = 1; rspData and rspError are stable.
  - ptr = (owner+1) mod NUM_REQ; go to IDLE.
- decOutStrobe outside WAIT is ignored; no state change, no response.
- Timer width = clog2(TIMEOUT); it never wraps, because it is cleared in ISSUE.
- Requesters that drop reqValid before being accepted are simply skipped; no request is queued internally.
- **Reset** (asserted at any time, including mid-transaction)
  - State = IDLE, ptr = 0, timer = 0, dataReg = 0, owner = 0.
  - All outputs 0: reqReady, rspValid, rspData, rspError, busy, decStrobe, decData.
  - Any in-flight transaction is dropped with no response. A late decOutStrobe after reset is ignored by the IDLE rule above.
- The decoder's own reset is the system's concern; this block never drives it.

## Timing
- Accept edge = t0. decStrobe is high in cycle t0+1.
- Decoder outStrobe sampled at edge tD: rspValid is high in the cycle following tD.
- Next accept possible in the cycle after RESPOND. Minimum spacing between accepts = L+3 cycles, where L = decoder latency in cycles from strobe to outStrobe.
- Timeout: rspValid with rspError = 1 is high in cycle t0+TIMEOUT+2.
- Fairness: a continuously requesting requester is served within NUM_REQ transactions.
- reqReady is combinational from reqValid and state. rspValid, rspData, rspError, decStrobe, decData and busy are registered.

## Test plan
- Single request, decoder model with L=2: requester 1 sends 0x00000007. Required: decStrobe one cycle after accept; rspValid = 0b0010, rspData = 0x00000005, rspError = 0.
- All 4 requesters request continuously from reset. Required: grant order 0,1,2,3,0,1; requester 3 sends 0x6 and gets 0x4.
- Decoder model never answers, TIMEOUT = 8. Required: rspValid[owner] 10 cycles after accept, rspError = 1, rspData = 0; next request is served normally.
- Decoder outStrobe coincides with the timeout edge (L tuned so the strobe lands on timer == TIMEOUT-1). Required: rspError = 0, correct data.
- Spurious decOutStrobe in IDLE, then rst asserted asynchronously mid-WAIT. Required: no rspValid in either case; all outputs 0 immediately on rst; ptr = 0; the first post-reset grant goes to the lowest active requester.
- Random: 1024 random words over 3..WIDTH bits from random requesters, decoder latency 1..5. Required: each response equals the binary of its Gray input, goes only to its owner, exactly once.
